branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 32, number of direct-mapped predictor entries (power of two, 4..256).
REQ-002 Parameter XLEN, default 32, address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 IF_PC  input  XLEN  PC of the instruction in fetch.
REQ-006 predicted  output  1  fetch-PC predicted taken; carried down the pipe and compared against Jump by the hazard unit.
REQ-007 predicted_target  output  XLEN  next PC when predicted=1; don't-care otherwise.
REQ-008 upd_valid  input  1  a branch/JAL/JALR resolved in EX this cycle.
REQ-009 upd_PC  input  XLEN  PC of the resolved instruction.
REQ-010 upd_taken  input  1  actual outcome (same meaning as Jump).
REQ-011 upd_target  input  XLEN  actual target address.
REQ-012 upd_uncond  input  1  resolved instruction is JAL/JALR.
REQ-013 upd_predicted  input  1  prediction originally issued for this instruction.
REQ-014 mispredict  output  1  upd_valid & (upd_predicted ^ upd_taken), combinational.
REQ-015 mispredict_count  output  32  registered count of mispredictions.

Function
REQ-016 Index = PC[IDX_W+1:2], IDX_W = log2(ENTRIES); tag = PC[XLEN-1:IDX_W+2]; PC[1:0] ignored on both ports.
REQ-017 Entry = valid, tag, target (XLEN), uncond flag, 2-bit counter: SN=00, WN=01, WT=10, ST=11.
REQ-018 Lookup is combinational from stored state: hit = valid & tag match; predicted = hit & (uncond | counter[1]); predicted_target = stored target.
REQ-019 Update writes at the rising edge when upd_valid=1; one update port; zero-cycle latency to the following cycle's lookup.
REQ-020 Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
REQ-021 Hit, conditional: taken -> counter +1 saturating at ST; not taken -> counter -1 saturating at SN; target rewritten only when taken.
REQ-022 Hit, unconditional: counter forced ST, target rewritten with upd_target (JALR target changes).
REQ-023 Miss (invalid or tag mismatch) with upd_taken=1: allocate/replace — valid=1, new tag, target=upd_target, uncond=upd_uncond, counter=ST if uncond else WT.
REQ-024 Miss with upd_taken=0: no state change (no eviction of an aliasing entry).
REQ-025 mispredict_count increments by 1 on each cycle mispredict=1; wraps 0xFFFFFFFF -> 0.
REQ-026 Predictor stalls are not its concern: IF_PC held by PCWrite=0 yields a stable predicted output; the pipeline asserts upd_valid exactly once per resolved instruction (never for a bubble).

Reset
REQ-027 rst_n=0 at a rising edge: all valid bits 0, all counters WN, targets/tags/uncond 0, mispredict_count 0.
REQ-028 Outputs during and after reset: predicted=0, predicted_target=0, mispredict=follows inputs, mispredict_count=0.
REQ-029 Reset has priority over a simultaneous upd_valid; the update is discarded.

Structure
REQ-030 Shared package holds counter-state encodings (SN/WN/WT/ST), default ENTRIES, and the index/tag width derivation.
REQ-031 One sub-module, sat_counter2: 2-bit saturating next-state function (inputs state, taken; output next state), instantiated once on the update path.
REQ-032 Storage as flip-flop arrays (no RAM macro); synchronous-reset clear of all entries in one cycle.

Verification
REQ-033 After reset, IF_PC=0x00000100 -> predicted=0; mispredict_count=0.
REQ-034 Update PC=0x100 taken target=0x200 conditional -> next cycle IF_PC=0x100 gives predicted=1, predicted_target=0x200; two not-taken updates -> predicted=0 (WT->WN->SN); third not-taken keeps SN.
REQ-035 JAL at 0x040 to 0x400 (uncond) -> predicted=1; JALR update with target 0x800 -> predicted_target=0x800; counter stays ST.
REQ-036 Alias: entry for 0x100 valid; not-taken update at 0x100+4*ENTRIES (0x180 for 32) -> 0x100 entry unchanged; taken update at 0x180 -> 0x100 now misses, 0x180 hits.
REQ-037 Same-cycle update and lookup of 0x100 on an empty table -> predicted=0 that cycle, 1 the next.
REQ-038 Three mispredicting updates with rst_n=0 asserted on the third -> count reaches 2, then 0; preload 0xFFFFFFFF path via 2^32 not required, check wrap by forced-value test.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: counter encodings, default table size and index/tag width helpers
package branch_predictor_pkg;
  typedef enum logic [1:0] {SN = 2'b00, WN = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  localparam int DEF_ENTRIES = 32;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: 2-bit saturating counter next-state function
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_e state_i,
  input  logic taken_i,
  output ctr_e next_o
);
  // step toward ST on taken, toward SN otherwise, holding at the ends
  always_comb
    next_o = taken_i ? (state_i == ST ? ST : ctr_e'(state_i + 2'd1))
                     : (state_i == SN ? SN : ctr_e'(state_i - 2'd1));
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters and a mispredict counter
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] IF_PC,
  output logic            predicted,
  output logic [XLEN-1:0] predicted_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_PC,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_uncond,
  input  logic            upd_predicted,
  output logic            mispredict,
  output logic [31:0]     mispredict_count
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(XLEN, ENTRIES);
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic             unc_q   [ENTRIES];
  ctr_e             ctr_q   [ENTRIES];
  logic [31:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit, wr_en, unc_d;
  logic [XLEN-1:0]  tgt_d;
  ctr_e             ctr_d, ctr_nx;
  logic             unused_pc_lsbs;
  assign f_idx = IF_PC[IDX_W+1:2];
  assign f_tag = IF_PC[XLEN-1:IDX_W+2];
  assign u_idx = upd_PC[IDX_W+1:2];
  assign u_tag = upd_PC[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^{IF_PC[1:0], upd_PC[1:0]};
  sat_counter2 u_sat (.state_i(ctr_q[u_idx]), .taken_i(upd_taken), .next_o(ctr_nx));
  // fetch-side lookup straight from stored state, no bypass of a same-cycle update
  always_comb begin
    predicted        = valid_q[f_idx] && tag_q[f_idx] == f_tag && (unc_q[f_idx] || ctr_q[f_idx][1]);
    predicted_target = tgt_q[f_idx];
  end
  // resolve-side entry rewrite: train on hit, allocate only on a taken miss
  always_comb begin
    u_hit      = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    wr_en      = upd_valid && (u_hit || upd_taken);
    ctr_d      = (!u_hit || upd_uncond) ? (upd_uncond ? ST : WT) : ctr_nx;
    tgt_d      = (upd_taken || upd_uncond) ? upd_target : tgt_q[u_idx];
    unc_d      = u_hit ? unc_q[u_idx] : upd_uncond;
    mispredict = upd_valid && (upd_predicted ^ upd_taken);
    cnt_d      = cnt_q + 32'(mispredict);
  end
  // table and counter state; reset clears every entry and drops any pending update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        unc_q[i]   <= 1'b0;
        ctr_q[i]   <= WN;
      end
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= tgt_d;
        unc_q[u_idx]   <= unc_d;
        ctr_q[u_idx]   <= ctr_d;
      end
      cnt_q <= cnt_d;
    end
  end
  assign mispredict_count = cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomized checks against a behavioural table model
module tb_branch_predictor;
  localparam int ENTRIES = 32;
  localparam int IDX_W = 5;
  logic        clk, rst_n;
  logic [31:0] IF_PC, predicted_target, upd_PC, upd_target, mispredict_count;
  logic        predicted, upd_valid, upd_taken, upd_uncond, upd_predicted, mispredict;
  int checks = 0, errors = 0;
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag [ENTRIES], m_tgt [ENTRIES];
  bit          m_unc [ENTRIES];
  int          m_ctr [ENTRIES];
  logic [31:0] m_cnt;

  branch_predictor #(.ENTRIES(ENTRIES), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .IF_PC(IF_PC), .predicted(predicted),
    .predicted_target(predicted_target), .upd_valid(upd_valid), .upd_PC(upd_PC),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_uncond(upd_uncond),
    .upd_predicted(upd_predicted), .mispredict(mispredict), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_unc[i] = 0; m_ctr[i] = 1;
    end
    m_cnt = 0;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i = int'((pc >> 2) % ENTRIES);
    return m_valid[i] && m_tag[i] == (pc >> (2 + IDX_W)) && (m_unc[i] || m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_tgt[int'((pc >> 2) % ENTRIES)];
  endfunction

  function automatic void m_update();
    int i;
    logic [31:0] t;
    bit hit;
    if (upd_valid && (upd_predicted != upd_taken)) m_cnt = m_cnt + 1;
    if (!upd_valid) return;
    i = int'((upd_PC >> 2) % ENTRIES);
    t = upd_PC >> (2 + IDX_W);
    hit = m_valid[i] && m_tag[i] == t;
    if (hit) begin
      if (upd_uncond) begin
        m_ctr[i] = 3; m_tgt[i] = upd_target;
      end else begin
        m_ctr[i] = upd_taken ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
        if (upd_taken) m_tgt[i] = upd_target;
      end
    end else if (upd_taken) begin
      m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = upd_target; m_unc[i] = upd_uncond; m_ctr[i] = upd_uncond ? 3 : 2;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset(); else m_update();
    @(negedge clk);
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic un, input logic pr);
    upd_valid = v; upd_PC = pc; upd_taken = tk; upd_target = tg; upd_uncond = un; upd_predicted = pr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_upd(0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    IF_PC = 32'h100;
    set_upd(1, 32'h100, 1, 32'h200, 0, 0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL reset_mispredict got=%0b exp=1", mispredict); end
    cyc();
    cyc();
    rst_n = 1'b1;
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL reset_predicted got=%0b exp=0", predicted); end
    checks++; if (predicted_target !== 32'h0) begin errors++; $display("FAIL reset_target got=%h exp=0", predicted_target); end
    checks++; if (mispredict_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", mispredict_count); end
  endtask

  task automatic test_cond();
    IF_PC = 32'h100;
    set_upd(1, 32'h100, 1, 32'h200, 0, 0);
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL cond_alloc_pred got=%0b exp=1", predicted); end
    checks++; if (predicted_target !== 32'h200) begin errors++; $display("FAIL cond_alloc_tgt got=%h exp=200", predicted_target); end
    for (int k = 0; k < 3; k++) begin
      set_upd(1, 32'h100, 0, 32'h999, 0, k == 0);
      cyc();
      set_upd(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL cond_nt%0d_pred got=%0b exp=0", k, predicted); end
    end
    set_upd(1, 32'h100, 1, 32'h204, 0, 0);
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL cond_sn_to_wn_pred got=%0b exp=0", predicted); end
    checks++; if (predicted_target !== 32'h204) begin errors++; $display("FAIL cond_taken_tgt got=%h exp=204", predicted_target); end
    set_upd(1, 32'h100, 1, 32'h208, 0, 0);
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL cond_wn_to_wt_pred got=%0b exp=1", predicted); end
    checks++; if (mispredict_count !== m_cnt) begin errors++; $display("FAIL cond_count got=%h exp=%h", mispredict_count, m_cnt); end
  endtask

  task automatic test_jal();
    IF_PC = 32'h40;
    set_upd(1, 32'h40, 1, 32'h400, 1, 0);
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL jal_pred got=%0b exp=1", predicted); end
    checks++; if (predicted_target !== 32'h400) begin errors++; $display("FAIL jal_tgt got=%h exp=400", predicted_target); end
    set_upd(1, 32'h40, 1, 32'h800, 1, 1);
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL jalr_pred got=%0b exp=1", predicted); end
    checks++; if (predicted_target !== 32'h800) begin errors++; $display("FAIL jalr_tgt got=%h exp=800", predicted_target); end
  endtask

  task automatic test_alias();
    do_reset();
    set_upd(1, 32'h100, 1, 32'h200, 0, 0);
    cyc();
    set_upd(1, 32'h180, 0, 32'h300, 0, 0);
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    IF_PC = 32'h100;
    #1;
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL alias_nt_keep_pred got=%0b exp=1", predicted); end
    checks++; if (predicted_target !== 32'h200) begin errors++; $display("FAIL alias_nt_keep_tgt got=%h exp=200", predicted_target); end
    IF_PC = 32'h180;
    #1;
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL alias_other_miss got=%0b exp=0", predicted); end
    set_upd(1, 32'h180, 1, 32'h300, 0, 0);
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    IF_PC = 32'h100;
    #1;
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL alias_evicted got=%0b exp=0", predicted); end
    IF_PC = 32'h183;
    #1;
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL alias_new_pred got=%0b exp=1", predicted); end
    checks++; if (predicted_target !== 32'h300) begin errors++; $display("FAIL alias_new_tgt got=%h exp=300", predicted_target); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    IF_PC = 32'h100;
    set_upd(1, 32'h100, 1, 32'h200, 0, 0);
    #1;
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL same_cycle_pre got=%0b exp=0", predicted); end
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL same_cycle_post got=%0b exp=1", predicted); end
  endtask

  task automatic test_mispredict_reset();
    do_reset();
    set_upd(1, 32'h10, 1, 32'h20, 0, 0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL mp_comb got=%0b exp=1", mispredict); end
    cyc();
    checks++; if (mispredict_count !== 32'd1) begin errors++; $display("FAIL mp_count1 got=%h exp=1", mispredict_count); end
    set_upd(1, 32'h14, 0, 32'h0, 0, 1);
    cyc();
    checks++; if (mispredict_count !== 32'd2) begin errors++; $display("FAIL mp_count2 got=%h exp=2", mispredict_count); end
    rst_n = 1'b0;
    set_upd(1, 32'h18, 1, 32'h30, 0, 0);
    cyc();
    rst_n = 1'b1;
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (mispredict_count !== 32'd0) begin errors++; $display("FAIL mp_count_reset got=%h exp=0", mispredict_count); end
    IF_PC = 32'h18;
    #1;
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL mp_reset_discard got=%0b exp=0", predicted); end
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    checks++; if (mispredict_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffffffff", mispredict_count); end
    set_upd(1, 32'h24, 0, 32'h0, 0, 1);
    cyc();
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (mispredict_count !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", mispredict_count); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic un;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      IF_PC = rand_pc();
      pc = rand_pc();
      un = ((pc >> 2) & 7) == 3;
      set_upd(1'($urandom_range(0, 1)), pc, un ? 1'b1 : 1'($urandom_range(0, 1)), $urandom, un, 1'($urandom_range(0, 1)));
      #1;
      checks++; if (predicted !== m_pred(IF_PC)) begin errors++; $display("FAIL rnd_pred n=%0d pc=%h got=%0b exp=%0b", n, IF_PC, predicted, m_pred(IF_PC)); end
      if (m_pred(IF_PC)) begin
        checks++; if (predicted_target !== m_target(IF_PC)) begin errors++; $display("FAIL rnd_tgt n=%0d pc=%h got=%h exp=%h", n, IF_PC, predicted_target, m_target(IF_PC)); end
      end
      checks++; if (mispredict !== (upd_valid && (upd_predicted != upd_taken))) begin errors++; $display("FAIL rnd_mp n=%0d got=%0b exp=%0b", n, mispredict, upd_valid && (upd_predicted != upd_taken)); end
      checks++; if (mispredict_count !== m_cnt) begin errors++; $display("FAIL rnd_count n=%0d got=%h exp=%h", n, mispredict_count, m_cnt); end
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    IF_PC = 0;
    set_upd(0, 0, 0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    test_reset();
    test_cond();
    test_jal();
    test_alias();
    test_same_cycle();
    test_mispredict_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
